ipsxe_floating_point_fma_unpack_v1_0: RTL

Registered operand unpack/classify stage of the FMA datapath (result = a*b + c), directly downstream of the denormal-flush stage. Takes the three flushed operands with a valid/ready handshake, splits them into sign/exponent/significand fields and classifies them. It computes the biased product exponent and resolves IEEE special cases so that the multiply/align stages only see finite, non-special work. A two-entry skid buffer gives full throughput with a registered `o_ready`.

---
 rtl/ipsxe_floating_point_fma_pkg.sv | 39 +++
 rtl/ipsxe_floating_point_fma_classify_v1_0.sv | 38 +++
 rtl/ipsxe_floating_point_fma_unpack_v1_0.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ipsxe_floating_point_fma_pkg.sv
// Shared definitions for the FMA front-end stages: default widths, operand
// class flag positions, special-value constructors and skid buffer states.
package ipsxe_floating_point_fma_pkg;

    localparam int FMA_EXP_WIDTH = 8;
    localparam int FMA_SIG_WIDTH = 23;
    localparam int FMA_BIAS      = (1 << (FMA_EXP_WIDTH - 1)) - 1;

    // Bit positions inside the per-operand class vector.
    localparam int CLS_ZERO = 0;
    localparam int CLS_INF  = 1;
    localparam int CLS_NAN  = 2;
    localparam int CLS_SNAN = 3;
    localparam int CLS_W    = 4;

    // Constructors return a 64-bit word; callers cast down to their format width.
    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set only.
    function automatic logic [63:0] fma_qnan(input int ew, input int sw);
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd1) << sw;
        r = r | (64'd1 << (sw - 1));
        return r;
    endfunction

    // Infinity with the given sign.
    function automatic logic [63:0] fma_inf(input logic sign, input int ew, input int sw);
        logic [63:0] r;
        r = ((64'd1 << ew) - 64'd1) << sw;
        r = r | (64'(sign) << (ew + sw));
        return r;
    endfunction

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ipsxe_floating_point_fma_classify_v1_0.sv
// Combinational field split and classification of one flushed operand.
module ipsxe_floating_point_fma_classify_v1_0
    import ipsxe_floating_point_fma_pkg::*;
#(
    parameter int EXP_WIDTH = FMA_EXP_WIDTH,
    parameter int SIG_WIDTH = FMA_SIG_WIDTH
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0] op,
    output logic                         sign,
    output logic [EXP_WIDTH-1:0]         exp,
    output logic [SIG_WIDTH:0]           sig,
    output logic [CLS_W-1:0]             cls
);

    logic [SIG_WIDTH-1:0] frac;
    logic                 exp_zero;
    logic                 exp_ones;

    assign sign     = op[EXP_WIDTH+SIG_WIDTH];
    assign exp      = op[EXP_WIDTH+SIG_WIDTH-1:SIG_WIDTH];
    assign frac     = op[SIG_WIDTH-1:0];
    assign exp_zero = (exp == '0);
    assign exp_ones = (exp == '1);

    // Operands arrive flushed, so a zero exponent always means zero: the
    // significand is forced to 0 regardless of any leftover fraction bits.
    assign sig = exp_zero ? '0 : {1'b1, frac};

    // Class flags.
    always_comb begin
        cls           = '0;
        cls[CLS_ZERO] = exp_zero;
        cls[CLS_INF]  = exp_ones & (frac == '0);
        cls[CLS_NAN]  = exp_ones & (frac != '0);
        cls[CLS_SNAN] = exp_ones & (frac != '0) & ~frac[SIG_WIDTH-1];
    end

endmodule

// File: rtl/ipsxe_floating_point_fma_unpack_v1_0.sv
// FMA operand unpack stage: classification, product exponent, IEEE special
// case resolution, and a two-entry skid buffer with registered ready.
//
//   state       | meaning
//   ------------+--------------------------------------------------
//   SKID_EMPTY  | no entry held, o_valid=0
//   SKID_ONE    | main entry presented on the outputs
//   SKID_FULL   | main presented, skid holds the next entry, o_ready=0
module ipsxe_floating_point_fma_unpack_v1_0
    import ipsxe_floating_point_fma_pkg::*;
#(
    parameter int EXP_WIDTH = FMA_EXP_WIDTH,
    parameter int SIG_WIDTH = FMA_SIG_WIDTH
) (
    input  logic                         i_aclk,
    input  logic                         i_aresetn,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_a,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_b,
    input  logic [EXP_WIDTH+SIG_WIDTH:0] i_c,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_sign_p,
    output logic                         o_sign_c,
    output logic [EXP_WIDTH+1:0]         o_exp_p,
    output logic [EXP_WIDTH-1:0]         o_exp_c,
    output logic [SIG_WIDTH:0]           o_sig_a,
    output logic [SIG_WIDTH:0]           o_sig_b,
    output logic [SIG_WIDTH:0]           o_sig_c,
    output logic                         o_special,
    output logic [EXP_WIDTH+SIG_WIDTH:0] o_special_res,
    output logic                         o_invalid
);

    localparam int FW = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int OW = 2 + (EXP_WIDTH + 2) + EXP_WIDTH + 3 * (SIG_WIDTH + 1) + 1 + FW + 1;
    localparam logic [EXP_WIDTH+1:0] BIAS    = (EXP_WIDTH + 2)'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [FW-1:0]        QNAN    = FW'(fma_qnan(EXP_WIDTH, SIG_WIDTH));
    localparam logic [FW-1:0]        INF_POS = FW'(fma_inf(1'b0, EXP_WIDTH, SIG_WIDTH));

    logic                 sa, sb, sc;
    logic [EXP_WIDTH-1:0] ea, eb, ec;
    logic [SIG_WIDTH:0]   siga, sigb, sigc;
    logic [CLS_W-1:0]     cla, clb, clc;

    ipsxe_floating_point_fma_classify_v1_0 #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls_a (
        .op(i_a), .sign(sa), .exp(ea), .sig(siga), .cls(cla)
    );
    ipsxe_floating_point_fma_classify_v1_0 #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls_b (
        .op(i_b), .sign(sb), .exp(eb), .sig(sigb), .cls(clb)
    );
    ipsxe_floating_point_fma_classify_v1_0 #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_cls_c (
        .op(i_c), .sign(sc), .exp(ec), .sig(sigc), .cls(clc)
    );

    logic                 sign_p;
    logic [EXP_WIDTH+1:0] exp_p;
    logic                 any_nan, any_snan;
    logic                 p_inf, p_zero, inf_x_zero, inf_sub;
    logic                 special;
    logic [FW-1:0]        special_res;
    logic                 invalid;

    assign sign_p = sa ^ sb;
    // Wraps in two's complement at EXP_WIDTH+2 bits; later stages handle range.
    assign exp_p  = {2'b00, ea} + {2'b00, eb} - BIAS;

    assign any_nan    = cla[CLS_NAN]  | clb[CLS_NAN]  | clc[CLS_NAN];
    assign any_snan   = cla[CLS_SNAN] | clb[CLS_SNAN] | clc[CLS_SNAN];
    assign p_inf      = cla[CLS_INF]  | clb[CLS_INF];
    assign p_zero     = cla[CLS_ZERO] | clb[CLS_ZERO];
    assign inf_x_zero = (cla[CLS_INF] & clb[CLS_ZERO]) | (clb[CLS_INF] & cla[CLS_ZERO]);
    // Only a genuinely infinite product can cancel against an infinite c.
    assign inf_sub    = p_inf & ~p_zero & ~any_nan & clc[CLS_INF] & (sign_p != sc);

    // Special-case priority mux.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        invalid     = 1'b0;
        if (any_nan | inf_x_zero | inf_sub) begin
            special     = 1'b1;
            special_res = QNAN;
            invalid     = any_snan | inf_x_zero | inf_sub;
        end else if (p_inf) begin
            special     = 1'b1;
            special_res = {sign_p, INF_POS[FW-2:0]};
        end else if (clc[CLS_INF]) begin
            special     = 1'b1;
            special_res = {sc, INF_POS[FW-2:0]};
        end else if (p_zero & clc[CLS_ZERO]) begin
            special     = 1'b1;
            special_res = {sign_p & sc, {(FW - 1){1'b0}}};
        end
    end

    logic [OW-1:0] new_w, main_q, skid_q;
    skid_state_t   state;
    logic          accept, fire;

    assign new_w  = {sign_p, sc, exp_p, ec, siga, sigb, sigc, special, special_res, invalid};
    assign accept = i_valid & o_ready;
    assign fire   = o_valid & i_ready;

    assign {o_sign_p, o_sign_c, o_exp_p, o_exp_c, o_sig_a, o_sig_b, o_sig_c,
            o_special, o_special_res, o_invalid} = main_q;

    // Skid buffer FSM; o_valid/o_ready are registered from the next state.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state   <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_q  <= new_w;
                        state   <= SKID_ONE;
                        o_valid <= 1'b1;
                        o_ready <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    case ({accept, fire})
                        2'b11: main_q <= new_w;
                        2'b10: begin
                            skid_q  <= new_w;
                            state   <= SKID_FULL;
                            o_ready <= 1'b0;
                        end
                        2'b01: begin
                            state   <= SKID_EMPTY;
                            o_valid <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                SKID_FULL: begin
                    if (fire) begin
                        main_q  <= skid_q;
                        state   <= SKID_ONE;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= SKID_EMPTY;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
